noc_dg_injector: RTL and testbench

//  Clocked transmitter that drives one mesh node's dg input (8-bit, 4-phase bundled-data req/ack).
//  A synchronous core pushes (dest, payload) words. They are buffered in a small FIFO.
//  The block serialises them onto the node's dg channel with a 4-phase return-to-zero handshake.
//  One instance per node (16 total), placed between the clocked core and the asynchronous node.

---
 rtl/noc_dg_injector_pkg.sv | 20 ++
 rtl/noc_dg_injector_if.sv | 13 +
 rtl/noc_dg_injector_sync_fifo.sv | 43 ++++
 rtl/noc_dg_injector.sv | 124 ++++++++++++
 tb/tb_noc_dg_injector.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_dg_injector_pkg.sv
// Shared NoC types: dg/db word layout and injector FSM states.
package noc_dg_injector_pkg;

    localparam int unsigned NODE_ADDR_W = 4;
    localparam int unsigned PAYLOAD_W   = 4;
    localparam int unsigned DG_W        = NODE_ADDR_W + PAYLOAD_W;

    typedef struct packed {
        logic [NODE_ADDR_W-1:0] dest;
        logic [PAYLOAD_W-1:0]   payload;
    } dg_word_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO
    } inj_state_t;

endpackage

// File: rtl/noc_dg_injector_if.sv
// Core-side push channel into the dg injector (valid/ready word offer).
interface noc_dg_injector_if;
    import noc_dg_injector_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [NODE_ADDR_W-1:0] in_dest;
    logic [PAYLOAD_W-1:0]   in_payload;

    modport master (output in_valid, output in_dest, output in_payload, input in_ready);
    modport slave  (input in_valid, input in_dest, input in_payload, output in_ready);

endinterface

// File: rtl/noc_dg_injector_sync_fifo.sv
// Single-clock FIFO; head word is always visible on dout. Shared with the db-side receiver.
module noc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign dout  = mem[rdPtr[AW-1:0]];

    // Pointer update; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) begin
                mem[wrPtr[AW-1:0]] <= din;
                wrPtr              <= wrPtr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rdPtr <= rdPtr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/noc_dg_injector.sv
// Clocked-to-async bridge: buffers core words and serialises them onto a
// node's dg port with a 4-phase return-to-zero bundled-data handshake.
module noc_dg_injector
    import noc_dg_injector_pkg::*;
#(
    parameter logic [NODE_ADDR_W-1:0] MY_IP     = 4'b0000,
    parameter int unsigned            DEPTH     = 4,
    parameter int unsigned            SETUP_CYC = 1,
    parameter int unsigned            CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    noc_dg_injector_if.slave  core,
    output logic              err_self,
    output logic              dg_req,
    input  logic              dg_ack,
    output logic [DG_W-1:0]   dg_data,
    output logic              busy,
    output logic [CNT_W-1:0]  sent_cnt
);

    localparam int unsigned SCNT_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    inj_state_t        state;
    logic [SCNT_W-1:0] setupCnt;
    logic              ackMeta;
    logic              ackS;
    logic              readyEn;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              accept;
    logic              selfHit;
    logic              push;
    logic              pop;
    dg_word_t          inWord;
    dg_word_t          head;

    // Core-side acceptance; self-addressed words are consumed but never stored.
    assign core.in_ready = readyEn && !fifoFull;
    assign accept        = core.in_valid && core.in_ready;
    assign selfHit       = (core.in_dest == MY_IP);
    assign push          = accept && !selfHit;
    assign pop           = (state == IDLE) && !fifoEmpty && !ackS;
    assign busy          = (state != IDLE) || !fifoEmpty;
    assign inWord        = '{dest: core.in_dest, payload: core.in_payload};

    noc_sync_fifo #(
        .WIDTH (DG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (inWord),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .dout  (head)
    );

    // Two-flop synchroniser for the asynchronous acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ackMeta <= 1'b0;
            ackS    <= 1'b0;
        end else begin
            ackMeta <= dg_ack;
            ackS    <= ackMeta;
        end
    end

    // Ready gating during reset and the one-cycle self-address error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            readyEn  <= 1'b0;
            err_self <= 1'b0;
        end else begin
            readyEn  <= 1'b1;
            err_self <= accept && selfHit;
        end
    end

    // Handshake FSM: launch only over a low ack, hold data until return-to-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            setupCnt <= '0;
            dg_req   <= 1'b0;
            dg_data  <= '0;
            sent_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifoEmpty && !ackS) begin
                        dg_data  <= head;
                        setupCnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    setupCnt <= setupCnt + SCNT_W'(1);
                    if (setupCnt == SCNT_W'(SETUP_CYC - 1)) begin
                        dg_req <= 1'b1;
                        state  <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ackS) begin
                        dg_req <= 1'b0;
                        state  <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ackS) begin
                        sent_cnt <= sent_cnt + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_dg_injector.sv
// Bench for noc_dg_injector: directed phases plus random traffic, scoreboard
// of expected dg words, protocol monitor and an ack responder model.
module tb_noc_dg_injector;
    import noc_dg_injector_pkg::*;

    localparam logic [3:0]  MY_IP     = 4'hA;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned SETUP_CYC = 2;
    localparam int unsigned CNT_W     = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             dg_ack = 1'b0;
    logic             err_self;
    logic             dg_req;
    logic [DG_W-1:0]  dg_data;
    logic             busy;
    logic [CNT_W-1:0] sent_cnt;

    noc_dg_injector_if coreIf ();

    noc_dg_injector #(
        .MY_IP     (MY_IP),
        .DEPTH     (DEPTH),
        .SETUP_CYC (SETUP_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .core     (coreIf),
        .err_self (err_self),
        .dg_req   (dg_req),
        .dg_ack   (dg_ack),
        .dg_data  (dg_data),
        .busy     (busy),
        .sent_cnt (sent_cnt)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model state
    logic [7:0]  expQ [$];
    int unsigned expSent = 0;

    // Ack responder controls
    bit          autoAck = 1'b0;
    bit          randAck = 1'b0;
    bit          manualAck = 1'b0;
    int unsigned ackDly = 3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Environment-side view of the acknowledge as the clocked domain sees it.
    logic s1 = 1'b0;
    logic s2 = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= dg_ack;
            s2 <= s1;
        end
    end

    // Node model: echoes dg_req onto dg_ack after a fixed or random delay.
    initial begin
        bit pend;
        int unsigned cnt;
        pend = 1'b0;
        cnt  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!autoAck) begin
                dg_ack = manualAck;
                pend   = 1'b0;
            end else if (dg_req !== dg_ack) begin
                if (!pend) begin
                    pend = 1'b1;
                    cnt  = randAck ? $urandom_range(0, ackDly) : ackDly;
                end
                if (cnt == 0) begin
                    dg_ack = dg_req;
                    pend   = 1'b0;
                end else begin
                    cnt--;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Protocol monitor and scoreboard, sampled just after each edge.
    initial begin
        logic       prevReq;
        logic       prevAcks;
        logic [7:0] prevData;
        logic [3:0] prevCnt;
        prevReq  = 1'b0;
        prevAcks = 1'b0;
        prevData = '0;
        prevCnt  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (prevReq || prevAcks)
                    check("dg_data_stable", 32'(dg_data), 32'(prevData));
                if (dg_req && !prevReq) begin
                    check("req_rise_ack_low", 32'(prevAcks), 32'd0);
                    check("word_available", 32'(expQ.size() != 0), 32'd1);
                    if (expQ.size() != 0)
                        check("dg_data_order", 32'(dg_data), 32'(expQ.pop_front()));
                    expSent++;
                end
                if (sent_cnt != prevCnt)
                    check("sent_cnt_step", 32'(sent_cnt), 32'(4'(prevCnt + 4'd1)));
            end
            prevReq  = reset ? 1'b0 : dg_req;
            prevAcks = reset ? 1'b0 : s2;
            prevData = dg_data;
            prevCnt  = sent_cnt;
        end
    end

    // Offer a word from a negedge; returns on the negedge after acceptance.
    task automatic pushWord(input logic [3:0] d, input logic [3:0] p);
        int n;
        n = 0;
        coreIf.in_valid   = 1'b1;
        coreIf.in_dest    = d;
        coreIf.in_payload = p;
        while (!coreIf.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("push_ready_timeout", 32'(n < 300), 32'd1);
        if (d != MY_IP)
            expQ.push_back({d, p});
        @(negedge clk);
    endtask

    task automatic idleIn();
        coreIf.in_valid = 1'b0;
    endtask

    task automatic waitIdle(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((busy || dg_req || dg_ack) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        logic [3:0] d;
        logic [3:0] p;

        coreIf.in_valid   = 1'b0;
        coreIf.in_dest    = '0;
        coreIf.in_payload = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(coreIf.in_ready), 32'd0);
        check("rst_dg_req", 32'(dg_req), 32'd0);
        check("rst_dg_data", 32'(dg_data), 32'd0);
        check("rst_err_self", 32'(err_self), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(coreIf.in_ready), 32'd1);

        // Single word, fixed 3-clock ack echo, latency check
        autoAck = 1'b1;
        randAck = 1'b0;
        ackDly  = 3;
        pushWord(4'h1, 4'h1);
        idleIn();
        check("t1_no_err", 32'(err_self), 32'd0);
        @(negedge clk);
        check("t1_data", 32'(dg_data), 32'h11);
        check("t1_req_setup", 32'(dg_req), 32'd0);
        repeat (SETUP_CYC - 1) @(negedge clk);
        check("t1_req_early", 32'(dg_req), 32'd0);
        @(negedge clk);
        check("t1_req_high", 32'(dg_req), 32'd1);
        waitIdle(100);
        check("t1_sent_cnt", 32'(sent_cnt), 32'(4'(expSent)));
        check("t1_busy", 32'(busy), 32'd0);

        // Fill FIFO while ack is held low
        autoAck   = 1'b0;
        manualAck = 1'b0;
        pushWord(4'h2, 4'h3);
        pushWord(4'h3, 4'h7);
        pushWord(4'h4, 4'hF);
        pushWord(4'h5, 4'hF);
        pushWord(4'h6, 4'h0);
        idleIn();
        check("t2_full_ready", 32'(coreIf.in_ready), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_req_first", 32'(dg_req), 32'd1);
        check("t2_data_first", 32'(dg_data), 32'h23);
        coreIf.in_valid   = 1'b1;
        coreIf.in_dest    = 4'h7;
        coreIf.in_payload = 4'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_still_full", 32'(coreIf.in_ready), 32'd0);
        end
        idleIn();
        autoAck = 1'b1;
        randAck = 1'b1;
        ackDly  = 4;
        waitIdle(500);
        check("t2_sent_cnt", 32'(sent_cnt), 32'(4'(expSent)));
        check("t2_all_delivered", 32'(expQ.size()), 32'd0);

        // Self-addressed word is dropped with an error pulse
        pushWord(MY_IP, 4'h5);
        idleIn();
        check("t3_err_pulse", 32'(err_self), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t3_err_clear", 32'(err_self), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t3_no_req", 32'(dg_req), 32'd0);
            check("t3_fifo_empty", 32'(busy), 32'd0);
            @(negedge clk);
        end
        pushWord(4'h2, 4'h5);
        idleIn();
        waitIdle(200);
        check("t3_sent_cnt", 32'(sent_cnt), 32'(4'(expSent)));
        check("t3_queue_empty", 32'(expQ.size()), 32'd0);

        // Reset during REQ_HI with ack high
        autoAck   = 1'b0;
        manualAck = 1'b0;
        pushWord(4'h6, 4'h9);
        idleIn();
        n = 0;
        while (!dg_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_req_timeout", 32'(n < 50), 32'd1);
        manualAck = 1'b1;
        @(negedge clk);
        reset   = 1'b1;
        expQ.delete();
        expSent = 0;
        @(negedge clk);
        check("t4_req_drop", 32'(dg_req), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_in_ready", 32'(coreIf.in_ready), 32'd0);
        check("t4_sent_cnt", 32'(sent_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pushWord(4'h7, 4'h3);
        idleIn();
        for (int i = 0; i < 4; i++) begin
            check("t4_stale_ack_hold", 32'(dg_req), 32'd0);
            @(negedge clk);
        end
        check("t4_word_pending", 32'(busy), 32'd1);
        manualAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_wait_sync", 32'(dg_req), 32'd0);
        end
        n = 0;
        while (!dg_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_launch", 32'(dg_req), 32'd1);
        check("t4_data", 32'(dg_data), 32'h73);
        autoAck = 1'b1;
        waitIdle(200);
        check("t4_sent_after_rst", 32'(sent_cnt), 32'(4'(expSent)));

        // Random traffic with random ack delays, sent_cnt wraps
        randAck = 1'b1;
        ackDly  = 4;
        for (int i = 0; i < 20; i++) begin
            d = 4'($urandom_range(0, 15));
            if (d == MY_IP)
                d = d + 4'd1;
            p = 4'($urandom_range(0, 15));
            pushWord(d, p);
            idleIn();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        waitIdle(3000);
        check("t6_sent_cnt", 32'(sent_cnt), 32'(4'(expSent)));
        check("t6_queue_empty", 32'(expQ.size()), 32'd0);
        check("t6_wrapped", 32'(expSent >= 17), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
